hazard_stall_ctrl: RTL and testbench
====================================

Name: hazard_stall_ctrl

Overview:
- Control-side counterpart of the ID→EX pipeline register. It decides, each cycle, whether the ID→EX register loads the decoded instruction, loads a bubble, or is flushed.
- Detects load-use hazards between the instruction in ID and the load in EX, and sequences multi-cycle stalls.
- Sequences front-end flushes when EX resolves a taken branch.
- Keeps saturating stall and flush performance counters.

Parameters:
- LOAD_STALL_CYCLES, 1: bubbles inserted per load-use hazard; legal range 1..15.
- FLUSH_CYCLES, 1: cycles the IF/ID register is flushed per taken branch; legal range 1..15.
- CNT_W, 16: width of each performance counter.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous reset, active-low (0 = reset asserted)
- id_valid  in  1  ID stage holds a real instruction
- id_src1  in  5  first source register index of the ID instruction
- id_src2  in  5  second source register index of the ID instruction
- id_two_src  in  1  id_src2 is actually read by the ID instruction
- exe_dest  in  5  dest output of the ID→EX register
- exe_mem_r_en  in  1  MEM_R_EN output of the ID→EX register (load in EX)
- exe_br_taken  in  1  brTaken_out output of the ID→EX register
- perf_clr  in  1  synchronous clear of both counters
- freeze_if_id  out  1  hold PC and the IF/ID register
- bubble_id_ex  out  1  force MEM_R_EN_IN, MEM_W_EN_IN, WB_EN_IN, brTaken_in and EXE_CMD_IN of the ID→EX register to 0
- flush_if_id  out  1  invalidate the IF/ID register
- stall_count  out  CNT_W  cycles with freeze_if_id = 1, saturating
- flush_count  out  CNT_W  cycles with flush_if_id = 1, saturating

Behaviour:
- Load-use hazard definition: hz = id_valid & exe_mem_r_en & ((exe_dest == id_src1) | (id_two_src & (exe_dest == id_src2))).
  - Register index 0 is not exempt.
- Output timing:
  - freeze_if_id, bubble_id_ex and flush_if_id are combinational from the current state and current inputs, giving zero-cycle response.
  - State, down-counter and performance counters are registered.
- States: IDLE, STALL, FLUSH. Internal down-counter rem is 4 bits.
- IDLE:
  - If exe_br_taken: flush=1, bubble=1, freeze=0. If FLUSH_CYCLES > 1, go to FLUSH with rem = FLUSH_CYCLES-1; otherwise stay in IDLE.
  - Else if hz: freeze=1, bubble=1, flush=0. If LOAD_STALL_CYCLES > 1, go to STALL with rem = LOAD_STALL_CYCLES-1; otherwise stay in IDLE.
  - Else: all three outputs 0.
- STALL:
  - freeze=1, bubble=1, flush=0.
  - rem decrements each cycle; when rem == 1, the next state is IDLE.
  - If exe_br_taken = 1 while in STALL, the branch wins: outputs and transition are exactly as the IDLE branch case, and the stall is abandoned.
- FLUSH:
  - flush=1, bubble=1, freeze=0.
  - rem decrements each cycle; when rem == 1, the next state is IDLE.
  - exe_br_taken during FLUSH restarts the count at rem = FLUSH_CYCLES-1; for FLUSH_CYCLES = 1 it returns to IDLE.
  - hz is ignored during FLUSH.
- Priority: branch flush > load-use stall > none. freeze and flush are never both 1.
- Performance counters:
  - Each counter increments by 1 on every cycle its output is 1, and holds at all-ones (saturates, no wrap).
  - perf_clr = 1 loads 0, and takes priority over increment in the same cycle.
- Reset (rst = 0, asynchronous):
  - state = IDLE, rem = 0, both counters = 0.
  - While rst is low, outputs are forced to freeze=0, bubble=1, flush=1.
  - Reset asserted mid-STALL or mid-FLUSH abandons the sequence immediately.
  - First cycle after release behaves as IDLE.
- Parameters outside their legal range are elaboration errors.

Decomposition:
- Shared pipeline package holds:
  - REG_IDX_W = 5
  - the state enumeration {IDLE, STALL, FLUSH}
  - the 4-bit rem width constant
- One sub-module, sat_counter (parameter W; ports clk, rst, clr, inc, count), instantiated twice for stall_count and flush_count.

Test Plan:
- Load-use, defaults: exe_mem_r_en=1, exe_dest=5, id_src1=5, id_valid=1 for 1 cycle, then load leaves EX -> freeze=1, bubble=1 for exactly 1 cycle; stall_count=1.
- Src2 gating: exe_dest=7, id_src2=7, id_two_src=0 -> no stall. Same with id_two_src=1 -> stall 1 cycle.
- LOAD_STALL_CYCLES=3 with a single hazard -> freeze high for 3 consecutive cycles, state returns to IDLE, stall_count=3.
- FLUSH_CYCLES=2, exe_br_taken pulse coincident with hz=1 -> flush=1 and bubble=1 for 2 cycles, freeze=0 throughout, flush_count=2, stall_count unchanged.
- CNT_W=4, hazard held 20 cycles -> stall_count reaches 15 and holds. Then perf_clr plus active stall in the same cycle -> count = 0.
- LOAD_STALL_CYCLES=3, assert rst low in the second STALL cycle -> immediate freeze=0, bubble=1, flush=1, counters 0. After release with no hazard -> all outputs 0.

Source files
------------

// File: rtl/hazard_stall_ctrl_pkg.sv
// Shared pipeline definitions for the ID->EX hazard/stall controller.
package hazard_stall_ctrl_pkg;

    localparam int unsigned REG_IDX_W = 5;
    localparam int unsigned REM_W     = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        STALL = 2'd1,
        FLUSH = 2'd2
    } state_e;

endpackage

// File: rtl/hazard_stall_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear and asynchronous active-low reset.
module sat_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // Clear wins over increment; an all-ones count holds instead of wrapping.
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc && (count_q != '1)) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/hazard_stall_ctrl.sv
// ID->EX control: load-use stall sequencing, taken-branch flush sequencing,
// and saturating stall/flush performance counters.
module hazard_stall_ctrl
    import hazard_stall_ctrl_pkg::*;
#(
    parameter int unsigned LOAD_STALL_CYCLES = 1,
    parameter int unsigned FLUSH_CYCLES      = 1,
    parameter int unsigned CNT_W             = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 id_valid,
    input  logic [REG_IDX_W-1:0] id_src1,
    input  logic [REG_IDX_W-1:0] id_src2,
    input  logic                 id_two_src,
    input  logic [REG_IDX_W-1:0] exe_dest,
    input  logic                 exe_mem_r_en,
    input  logic                 exe_br_taken,
    input  logic                 perf_clr,
    output logic                 freeze_if_id,
    output logic                 bubble_id_ex,
    output logic                 flush_if_id,
    output logic [CNT_W-1:0]     stall_count,
    output logic [CNT_W-1:0]     flush_count
);

    if ((LOAD_STALL_CYCLES < 1) || (LOAD_STALL_CYCLES > 15)) begin : g_bad_lsc
        $error("hazard_stall_ctrl: LOAD_STALL_CYCLES must be in 1..15");
    end
    if ((FLUSH_CYCLES < 1) || (FLUSH_CYCLES > 15)) begin : g_bad_fc
        $error("hazard_stall_ctrl: FLUSH_CYCLES must be in 1..15");
    end
    if (CNT_W < 1) begin : g_bad_cnt
        $error("hazard_stall_ctrl: CNT_W must be at least 1");
    end

    localparam logic [REM_W-1:0] STALL_RELOAD = REM_W'(LOAD_STALL_CYCLES - 1);
    localparam logic [REM_W-1:0] FLUSH_RELOAD = REM_W'(FLUSH_CYCLES - 1);
    localparam logic [REM_W-1:0] REM_LAST     = REM_W'(1);

    state_e           state_q, state_d;
    logic [REM_W-1:0] rem_q, rem_d;
    logic             hz;
    logic             freeze_c, bubble_c, flush_c;

    assign hz = id_valid & exe_mem_r_en &
                ((exe_dest == id_src1) | (id_two_src & (exe_dest == id_src2)));

    // A taken branch behaves identically in every state, so it is decoded
    // ahead of the state case; this also covers the restart during FLUSH.
    always_comb begin
        state_d  = state_q;
        rem_d    = rem_q;
        freeze_c = 1'b0;
        bubble_c = 1'b0;
        flush_c  = 1'b0;
        if (exe_br_taken) begin
            flush_c  = 1'b1;
            bubble_c = 1'b1;
            if (FLUSH_CYCLES > 1) begin
                state_d = FLUSH;
                rem_d   = FLUSH_RELOAD;
            end else begin
                state_d = IDLE;
                rem_d   = '0;
            end
        end else begin
            case (state_q)
                STALL: begin
                    freeze_c = 1'b1;
                    bubble_c = 1'b1;
                    rem_d    = rem_q - 1'b1;
                    if (rem_q == REM_LAST) begin
                        state_d = IDLE;
                    end
                end
                FLUSH: begin
                    flush_c  = 1'b1;
                    bubble_c = 1'b1;
                    rem_d    = rem_q - 1'b1;
                    if (rem_q == REM_LAST) begin
                        state_d = IDLE;
                    end
                end
                default: begin
                    if (hz) begin
                        freeze_c = 1'b1;
                        bubble_c = 1'b1;
                        if (LOAD_STALL_CYCLES > 1) begin
                            state_d = STALL;
                            rem_d   = STALL_RELOAD;
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
        end
    end

    // While reset is held the ID->EX register is bubbled and IF/ID flushed.
    assign freeze_if_id = rst & freeze_c;
    assign bubble_id_ex = ~rst | bubble_c;
    assign flush_if_id  = ~rst | flush_c;

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (perf_clr),
        .inc   (freeze_if_id),
        .count (stall_count)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (perf_clr),
        .inc   (flush_if_id),
        .count (flush_count)
    );

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Bench for hazard_stall_ctrl: two parameterisations driven in lockstep and
// checked against a remaining-cycle-count reference model.
module tb_hazard_stall_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       id_valid = 1'b0;
    logic [4:0] id_src1 = '0;
    logic [4:0] id_src2 = '0;
    logic       id_two_src = 1'b0;
    logic [4:0] exe_dest = '0;
    logic       exe_mem_r_en = 1'b0;
    logic       exe_br_taken = 1'b0;
    logic       perf_clr = 1'b0;

    logic        a_fz, a_bb, a_fl;
    logic [15:0] a_sc, a_fc;
    logic        b_fz, b_bb, b_fl;
    logic [3:0]  b_sc, b_fc;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    hazard_stall_ctrl u_a (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_src1(id_src1),
        .id_src2(id_src2), .id_two_src(id_two_src), .exe_dest(exe_dest),
        .exe_mem_r_en(exe_mem_r_en), .exe_br_taken(exe_br_taken),
        .perf_clr(perf_clr), .freeze_if_id(a_fz), .bubble_id_ex(a_bb),
        .flush_if_id(a_fl), .stall_count(a_sc), .flush_count(a_fc)
    );

    hazard_stall_ctrl #(.LOAD_STALL_CYCLES(3), .FLUSH_CYCLES(2), .CNT_W(4)) u_b (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_src1(id_src1),
        .id_src2(id_src2), .id_two_src(id_two_src), .exe_dest(exe_dest),
        .exe_mem_r_en(exe_mem_r_en), .exe_br_taken(exe_br_taken),
        .perf_clr(perf_clr), .freeze_if_id(b_fz), .bubble_id_ex(b_bb),
        .flush_if_id(b_fl), .stall_count(b_sc), .flush_count(b_fc)
    );

    // Reference model: cycles still owed to an active stall or flush.
    int lsc [2] = '{1, 3};
    int fcy [2] = '{1, 2};
    int cmax[2] = '{65535, 15};
    int stall_left[2] = '{0, 0};
    int flush_left[2] = '{0, 0};
    int m_sc[2] = '{0, 0};
    int m_fc[2] = '{0, 0};

    function automatic bit hazard();
        return id_valid && exe_mem_r_en &&
               ((exe_dest == id_src1) || (id_two_src && (exe_dest == id_src2)));
    endfunction

    function automatic logic [2:0] model_out(input int k);
        if (!rst)                return 3'b011;
        if (exe_br_taken)        return 3'b011;
        if (flush_left[k] > 0)   return 3'b011;
        if (stall_left[k] > 0)   return 3'b110;
        if (hazard())            return 3'b110;
        return 3'b000;
    endfunction

    task automatic model_tick();
        for (int k = 0; k < 2; k++) begin
            logic [2:0] o;
            o = model_out(k);
            if (!rst) begin
                stall_left[k] = 0; flush_left[k] = 0; m_sc[k] = 0; m_fc[k] = 0;
            end else begin
                if (exe_br_taken) begin
                    flush_left[k] = fcy[k] - 1; stall_left[k] = 0;
                end else if (flush_left[k] > 0) begin
                    flush_left[k]--;
                end else if (stall_left[k] > 0) begin
                    stall_left[k]--;
                end else if (hazard()) begin
                    stall_left[k] = lsc[k] - 1;
                end
                if (perf_clr) begin
                    m_sc[k] = 0; m_fc[k] = 0;
                end else begin
                    if (o[2] && m_sc[k] < cmax[k]) m_sc[k]++;
                    if (o[0] && m_fc[k] < cmax[k]) m_fc[k]++;
                end
            end
        end
    endtask

    task automatic check_all(input string tag);
        logic [2:0] obs, exp;
        int sc, fc;
        if (!rst) begin
            for (int k = 0; k < 2; k++) begin
                stall_left[k] = 0; flush_left[k] = 0; m_sc[k] = 0; m_fc[k] = 0;
            end
        end
        for (int k = 0; k < 2; k++) begin
            obs = (k == 0) ? {a_fz, a_bb, a_fl} : {b_fz, b_bb, b_fl};
            sc  = (k == 0) ? int'(a_sc) : int'(b_sc);
            fc  = (k == 0) ? int'(a_fc) : int'(b_fc);
            exp = model_out(k);
            checks++;
            assert (obs === exp) else begin
                errors++;
                $error("FAIL %s dut%0d outputs{frz,bub,fl} got %b expected %b", tag, k, obs, exp);
            end
            checks++;
            assert (sc === m_sc[k]) else begin
                errors++;
                $error("FAIL %s dut%0d stall_count got %0d expected %0d", tag, k, sc, m_sc[k]);
            end
            checks++;
            assert (fc === m_fc[k]) else begin
                errors++;
                $error("FAIL %s dut%0d flush_count got %0d expected %0d", tag, k, fc, m_fc[k]);
            end
        end
    endtask

    task automatic cycle(input string tag);
        @(negedge clk);
        check_all(tag);
        model_tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_val(input string tag, input int got, input int want);
        checks++;
        assert (got === want) else begin
            errors++;
            $error("FAIL %s got %0d expected %0d", tag, got, want);
        end
    endtask

    task automatic idle_inputs();
        id_valid = 0; id_src1 = 0; id_src2 = 0; id_two_src = 0;
        exe_dest = 0; exe_mem_r_en = 0; exe_br_taken = 0; perf_clr = 0;
    endtask

    initial begin
        idle_inputs();
        #2;
        check_all("reset_state");
        @(posedge clk); #1;
        rst = 1;
        cycle("post_reset_idle");

        // Single load-use hazard on src1.
        exe_mem_r_en = 1; exe_dest = 5; id_src1 = 5; id_valid = 1;
        cycle("lu_src1");
        idle_inputs();
        for (int i = 0; i < 4; i++) cycle("lu_src1_drain");
        check_val("lu_stall_cnt_a", int'(a_sc), 1);
        check_val("lu_stall_cnt_b", int'(b_sc), 3);

        // src2 only matters when id_two_src is set.
        exe_mem_r_en = 1; exe_dest = 7; id_src1 = 3; id_src2 = 7; id_valid = 1; id_two_src = 0;
        cycle("src2_gated");
        id_two_src = 1;
        cycle("src2_used");
        idle_inputs();
        for (int i = 0; i < 4; i++) cycle("src2_drain");

        // Branch coincident with a hazard: flush wins.
        exe_mem_r_en = 1; exe_dest = 9; id_src1 = 9; id_valid = 1; exe_br_taken = 1;
        cycle("br_vs_hz");
        exe_br_taken = 0;
        cycle("br_vs_hz_flush2");
        idle_inputs();
        for (int i = 0; i < 3; i++) cycle("br_drain");

        // Hazard held 20 cycles to saturate the narrow counter.
        perf_clr = 1;
        cycle("pre_sat_clear");
        perf_clr = 0;
        exe_mem_r_en = 1; exe_dest = 2; id_src1 = 2; id_valid = 1;
        for (int i = 0; i < 20; i++) cycle("hold_hz");
        check_val("sat_stall_cnt_b", int'(b_sc), 15);
        perf_clr = 1;
        cycle("clr_with_stall");
        perf_clr = 0;
        check_val("clr_stall_cnt_b", int'(b_sc), 0);
        idle_inputs();
        for (int i = 0; i < 4; i++) cycle("sat_drain");

        // Reset in the middle of a multi-cycle stall.
        exe_mem_r_en = 1; exe_dest = 4; id_src1 = 4; id_valid = 1;
        cycle("rst_mid_hz");
        idle_inputs();
        cycle("rst_mid_stall1");
        rst = 0;
        #1;
        check_all("rst_mid_stall_async");
        check_val("rst_b_freeze", int'(b_fz), 0);
        @(posedge clk); #1;
        rst = 1;
        cycle("after_rst_release");

        // Randomised traffic with a narrow register space to make hazards common.
        for (int i = 0; i < 400; i++) begin
            id_valid     = 1'($urandom_range(0, 3) != 0);
            id_src1      = 5'($urandom_range(0, 3));
            id_src2      = 5'($urandom_range(0, 3));
            id_two_src   = 1'($urandom_range(0, 1));
            exe_dest     = 5'($urandom_range(0, 3));
            exe_mem_r_en = 1'($urandom_range(0, 2) != 0);
            exe_br_taken = 1'($urandom_range(0, 7) == 0);
            perf_clr     = 1'($urandom_range(0, 31) == 0);
            if ($urandom_range(0, 63) == 0) begin
                rst = 0;
                #1;
                check_all("rand_async_rst");
                @(posedge clk); #1;
                rst = 1;
            end
            cycle("random");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
